hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
// Hazard/forwarding controller for the 5-stage pipelined datapath. Decodes the IF/ID instruction,
// tracks destination register and write/load flags of the EX and MEM stages in shadow registers,
// drives the datapath's EX/MEM forward-mux selects, and stalls the front end with bubbles on
// load-use hazards. Sits beside the datapath; fetch unit consumes stall, control unit consumes bubble.
// PARAMETERS
// LOAD_BUBBLES  1   bubbles inserted per load-use hazard (legal 1..3)
// CNT_W         16  width of saturating stall-cycle counter
// PORTS
// clk            in   1      system clock, all state updates on rising edge
// rst            in   1      synchronous reset, active-high
// id_instr       in   32     instruction in IF/ID (datapath if_id_forward)
// id_reg_wr      in   1      RegWr decoded for id_instr
// id_reg_dst     in   1      RegDst decoded for id_instr (1 = rd, 0 = rt)
// id_mem_to_reg  in   1      MemToReg decoded for id_instr (1 = load)
// flush          in   1      squash id_instr (taken branch/jump/jr)
// ex_forward_a   out  1      select ALUout onto Da path
// ex_forward_b   out  1      select ALUout onto Db path
// mem_forward_a  out  1      select Dw onto Da path
// mem_forward_b  out  1      select Dw onto Db path
// stall          out  1      hold PC and IF/ID this cycle
// bubble         out  1      force RegWr/MemWr/MemToReg to 0 into ID/EX this cycle
// stall_count    out  CNT_W  cycles spent with stall=1, saturating
// BEHAVIOUR
// - Decode: rs=id_instr[25:21], rt=id_instr[20:16], rd=[15:11], op=[31:26]. uses_rs always;
//   uses_rt when op in {RTYPE, SW, BEQ, BNE}. id_aw = id_reg_dst ? rd : rt.
// - Shadow stages (registered): EX{aw,wr,ld} <= bubble ? 0 : {id_aw,id_reg_wr,id_mem_to_reg};
//   MEM <= EX every cycle, including stall cycles (downstream never stalls).
// - Forward (combinational from shadow regs + id_instr): ex_forward_x = EX.wr & ~EX.ld &
//   EX.aw==src_x & src_x!=0 & uses_x; mem_forward_x = MEM.wr & MEM.aw==src_x & src_x!=0 & uses_x.
//   Both may assert; datapath gives EX priority. Forwards are 0 when flush=1.
// - Register $0 never forwarded, never causes a stall. WB needs no forward (regfile writes on ~clk).
// - Load-use hazard: EX.ld & EX.wr & EX.aw!=0 & (EX.aw==rs&uses_rs | EX.aw==rt&uses_rt) & ~flush.
// - FSM RUN/STALL, bubble counter bcnt (2 bits):
//   RUN: hazard -> stall=1,bubble=1; if LOAD_BUBBLES==1 stay RUN else go STALL, bcnt<=LOAD_BUBBLES-1.
//   STALL: stall=1,bubble=1, bcnt<=bcnt-1; bcnt==1 -> RUN. flush in STALL -> RUN immediately,
//   stall=0, bubble=1.
// - In RUN with LOAD_BUBBLES==1, hazard re-evaluates next cycle against bubble in EX, so exactly one
//   stall cycle; loaded value then arrives via mem_forward.
// - flush (any state): bubble=1, stall=0; flush wins over a simultaneous hazard.
// - stall_count += 1 on each stall=1 cycle, holds at all-ones.
// - Reset: state RUN, bcnt 0, all shadow fields 0, stall_count 0 -> every output 0 the cycle after
//   rst. rst mid-stall abandons the stall; bubble is 0 during rst.
// STRUCTURE
// - Package hazard_pkg: opcode localparams (OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04,
//   OP_BNE=6'h05), state enum hz_state_t {HZ_RUN, HZ_STALL}, struct stage_info_t {aw[4:0], wr, ld}.
// - One sub-module: hazard_stage_reg (stage_info_t register, sync rst, zero on rst or bubble
//   input), instantiated for EX and MEM shadows. Decode, FSM and counter stay in the top.
// TESTING
// - add $3,$1,$2 then add $4,$3,$5 -> 2nd cycle ex_forward_a=1, ex_forward_b=0, stall=0.
// - add $3,.. ; nop ; sub $6,$7,$3 -> mem_forward_b=1, ex_forward_b=0 when sub in ID.
// - lw $8,0($1) then add $9,$8,$2 -> stall=1,bubble=1 one cycle, then mem_forward_a=1; stall_count=1.
// - LOAD_BUBBLES=3, same lw/add -> stall=1 exactly 3 cycles, no forward afterwards; stall_count=3.
// - lw $0,0($1) then add $9,$0,$0 -> no stall, no forwards; addi $8,$8,1 after lw $8 -> stall
//   (rs only); sw $8,0($2) after lw $8 -> stall via rt.
// - Hazard with flush=1 same cycle -> stall=0,bubble=1; rst asserted mid-stall -> next cycle all 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and opcode constants for the hazard/forwarding controller.
package hazard_pkg;

   // Opcodes that matter to operand-usage decode
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   typedef enum logic {
      HZ_RUN,
      HZ_STALL
   } hz_state_t;

   // Destination / write / load flags carried alongside an instruction in EX or MEM
   typedef struct packed {
      logic [4:0] aw;
      logic       wr;
      logic       ld;
   } stage_info_t;

   // rt is a source operand only for R-type, stores and conditional branches;
   // for every other format it is a destination or unused.
   function automatic logic op_uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between the datapath/control side (master) and the hazard controller (slave).
interface hazard_forward_ctrl_if #(
   parameter int unsigned CNT_W = 16
);

   logic [31:0]      id_instr;
   logic             id_reg_wr;
   logic             id_reg_dst;
   logic             id_mem_to_reg;
   logic             flush;

   logic             ex_forward_a;
   logic             ex_forward_b;
   logic             mem_forward_a;
   logic             mem_forward_b;
   logic             stall;
   logic             bubble;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_instr,
      output id_reg_wr,
      output id_reg_dst,
      output id_mem_to_reg,
      output flush,
      input  ex_forward_a,
      input  ex_forward_b,
      input  mem_forward_a,
      input  mem_forward_b,
      input  stall,
      input  bubble,
      input  stall_count
   );

   modport slave (
      input  id_instr,
      input  id_reg_wr,
      input  id_reg_dst,
      input  id_mem_to_reg,
      input  flush,
      output ex_forward_a,
      output ex_forward_b,
      output mem_forward_a,
      output mem_forward_b,
      output stall,
      output bubble,
      output stall_count
   );

endinterface

// File: rtl/hazard_stage_reg.sv
// Shadow copy of one pipeline stage's destination/write/load flags.
// Cleared on reset or when a bubble is being injected into this stage.
module hazard_stage_reg
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  stage_info_t d_i,
   output stage_info_t q_o
);

   stage_info_t info_q;

   // Capture the upstream stage every cycle; a cleared entry looks like a nop
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         info_q <= '0;
      end else begin
         info_q <= d_i;
      end
   end

   assign q_o = info_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline. Shadows the EX and MEM
// destination info, drives the forward-mux selects and stalls the front end on
// load-use hazards, inserting LOAD_BUBBLES bubbles (legal range 1..3).
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_BUBBLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input logic                  clk,
   input logic                  rst,
   hazard_forward_ctrl_if.slave bus
);

   // Bubbles still to go after the first one, loaded on entry to HZ_STALL
   localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  id_aw;
   logic        uses_rt;

   stage_info_t ex_d;
   stage_info_t ex_q;
   stage_info_t mem_q;

   logic        ex_fwd_a;
   logic        ex_fwd_b;
   logic        mem_fwd_a;
   logic        mem_fwd_b;
   logic        load_use;
   logic        stall;
   logic        bubble;

   hz_state_t   state_q;
   logic [1:0]  bcnt_q;

   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;

   // ---------------------------------------------------------------------------------------
   // Decode of the instruction sitting in IF/ID (rs is always treated as a source)
   // ---------------------------------------------------------------------------------------
   assign op      = bus.id_instr[31:26];
   assign rs      = bus.id_instr[25:21];
   assign rt      = bus.id_instr[20:16];
   assign rd      = bus.id_instr[15:11];
   assign uses_rt = op_uses_rt(op);
   assign id_aw   = bus.id_reg_dst ? rd : rt;

   // ---------------------------------------------------------------------------------------
   // Shadow stages: EX takes the decoded IF/ID info (or a bubble), MEM follows EX
   // unconditionally since nothing downstream of ID ever stalls.
   // ---------------------------------------------------------------------------------------
   assign ex_d = '{aw: id_aw, wr: bus.id_reg_wr, ld: bus.id_mem_to_reg};

   hazard_stage_reg u_ex_stage (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bubble),
      .d_i   (ex_d),
      .q_o   (ex_q)
   );

   hazard_stage_reg u_mem_stage (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .d_i   (ex_q),
      .q_o   (mem_q)
   );

   // Forward selects: a load in EX has no result yet, so EX never forwards it.
   // WB needs no path because the register file writes on the falling edge.
   always_comb begin
      ex_fwd_a  = ex_q.wr & ~ex_q.ld & (ex_q.aw == rs) & (rs != 5'd0);
      ex_fwd_b  = ex_q.wr & ~ex_q.ld & (ex_q.aw == rt) & (rt != 5'd0) & uses_rt;
      mem_fwd_a = mem_q.wr & (mem_q.aw == rs) & (rs != 5'd0);
      mem_fwd_b = mem_q.wr & (mem_q.aw == rt) & (rt != 5'd0) & uses_rt;
      if (bus.flush) begin
         ex_fwd_a  = 1'b0;
         ex_fwd_b  = 1'b0;
         mem_fwd_a = 1'b0;
         mem_fwd_b = 1'b0;
      end
   end

   // Load in EX whose destination is a live source of the IF/ID instruction
   always_comb begin
      load_use = ex_q.ld & ex_q.wr & (ex_q.aw != 5'd0) & ~bus.flush &
                 ((ex_q.aw == rs) | ((ex_q.aw == rt) & uses_rt));
   end

   // Stall/bubble: flush beats any hazard, and nothing is asserted while in reset
   always_comb begin
      stall  = 1'b0;
      bubble = 1'b0;
      if (!rst) begin
         if (bus.flush) begin
            bubble = 1'b1;
         end else if ((state_q == HZ_STALL) || load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Bubble sequencer. With one bubble the hazard clears itself next cycle (EX then holds
   // the bubble), so HZ_STALL is only used for the extra bubbles of longer settings.
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HZ_RUN;
         bcnt_q  <= 2'd0;
      end else begin
         unique case (state_q)
            HZ_RUN: begin
               if (load_use && (LOAD_BUBBLES > 1)) begin
                  state_q <= HZ_STALL;
                  bcnt_q  <= BCNT_INIT;
               end
            end
            HZ_STALL: begin
               if (bus.flush) begin
                  state_q <= HZ_RUN;
                  bcnt_q  <= 2'd0;
               end else begin
                  bcnt_q <= bcnt_q - 2'd1;
                  if (bcnt_q == 2'd1) begin
                     state_q <= HZ_RUN;
                  end
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------
   // Saturating count of cycles spent stalled
   // ---------------------------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.ex_forward_a  = ex_fwd_a;
   assign bus.ex_forward_b  = ex_fwd_b;
   assign bus.mem_forward_a = mem_fwd_a;
   assign bus.mem_forward_b = mem_fwd_b;
   assign bus.stall         = stall;
   assign bus.bubble        = bubble;
   assign bus.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: one instance with a single load bubble and
// one with three, driven in turn. Expected outputs are queued as each step is driven
// and popped/compared at the falling edge of that cycle.
module tb_hazard_forward_ctrl;
   import hazard_pkg::*;

   localparam int unsigned CNT_W = 16;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] OP_ADDI = 6'h08;

   // {reg_wr, reg_dst, mem_to_reg}
   localparam logic [2:0] CTL_R    = 3'b110;
   localparam logic [2:0] CTL_LW   = 3'b101;
   localparam logic [2:0] CTL_ADDI = 3'b100;
   localparam logic [2:0] CTL_SW   = 3'b000;
   localparam logic [2:0] CTL_NOP  = 3'b000;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct {
      logic [3:0]       fwd;   // {ex_a, ex_b, mem_a, mem_b}
      logic             stall;
      logic             bubble;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk;
   logic rst;

   int n_assert;
   int n_fail;

   exp_t exp_q[$];

   hazard_forward_ctrl_if #(.CNT_W(CNT_W)) ifa ();
   hazard_forward_ctrl_if #(.CNT_W(CNT_W)) ifb ();

   hazard_forward_ctrl #(
      .LOAD_BUBBLES (1),
      .CNT_W        (CNT_W)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   hazard_forward_ctrl #(
      .LOAD_BUBBLES (3),
      .CNT_W        (CNT_W)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic exp_t ex(input logic [3:0] fwd, input logic st, input logic bb,
                               input logic [CNT_W-1:0] cnt);
      exp_t e;
      e.fwd    = fwd;
      e.stall  = st;
      e.bubble = bb;
      e.cnt    = cnt;
      return e;
   endfunction

   task automatic cmp(input string tag, input string fld, input logic [CNT_W-1:0] obs,
                      input logic [CNT_W-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, expv);
      end
   endtask

   task automatic check(input string tag, input bit sel_b);
      exp_t e;
      e = exp_q.pop_front();
      if (sel_b) begin
         cmp(tag, "ex_forward_a",  CNT_W'(ifb.ex_forward_a),  CNT_W'(e.fwd[3]));
         cmp(tag, "ex_forward_b",  CNT_W'(ifb.ex_forward_b),  CNT_W'(e.fwd[2]));
         cmp(tag, "mem_forward_a", CNT_W'(ifb.mem_forward_a), CNT_W'(e.fwd[1]));
         cmp(tag, "mem_forward_b", CNT_W'(ifb.mem_forward_b), CNT_W'(e.fwd[0]));
         cmp(tag, "stall",         CNT_W'(ifb.stall),         CNT_W'(e.stall));
         cmp(tag, "bubble",        CNT_W'(ifb.bubble),        CNT_W'(e.bubble));
         cmp(tag, "stall_count",   ifb.stall_count,           e.cnt);
      end else begin
         cmp(tag, "ex_forward_a",  CNT_W'(ifa.ex_forward_a),  CNT_W'(e.fwd[3]));
         cmp(tag, "ex_forward_b",  CNT_W'(ifa.ex_forward_b),  CNT_W'(e.fwd[2]));
         cmp(tag, "mem_forward_a", CNT_W'(ifa.mem_forward_a), CNT_W'(e.fwd[1]));
         cmp(tag, "mem_forward_b", CNT_W'(ifa.mem_forward_b), CNT_W'(e.fwd[0]));
         cmp(tag, "stall",         CNT_W'(ifa.stall),         CNT_W'(e.stall));
         cmp(tag, "bubble",        CNT_W'(ifa.bubble),        CNT_W'(e.bubble));
         cmp(tag, "stall_count",   ifa.stall_count,           e.cnt);
      end
   endtask

   task automatic idle_all();
      ifa.id_instr = NOP; ifa.id_reg_wr = 1'b0; ifa.id_reg_dst = 1'b0;
      ifa.id_mem_to_reg = 1'b0; ifa.flush = 1'b0;
      ifb.id_instr = NOP; ifb.id_reg_wr = 1'b0; ifb.id_reg_dst = 1'b0;
      ifb.id_mem_to_reg = 1'b0; ifb.flush = 1'b0;
   endtask

   // One cycle: drive the selected instance (the other sees a nop), queue the
   // expectation, compare at the falling edge, then advance past the rising edge.
   task automatic step(input string tag, input bit sel_b, input bit rst_v,
                       input logic [31:0] instr, input logic [2:0] ctl, input bit fl,
                       input exp_t e);
      idle_all();
      if (sel_b) begin
         ifb.id_instr = instr; ifb.id_reg_wr = ctl[2]; ifb.id_reg_dst = ctl[1];
         ifb.id_mem_to_reg = ctl[0]; ifb.flush = fl;
      end else begin
         ifa.id_instr = instr; ifa.id_reg_wr = ctl[2]; ifa.id_reg_dst = ctl[1];
         ifa.id_mem_to_reg = ctl[0]; ifa.flush = fl;
      end
      rst = rst_v;
      exp_q.push_back(e);
      @(negedge clk);
      check(tag, sel_b);
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      n_assert = 0;
      n_fail   = 0;
      idle_all();
      repeat (2) @(posedge clk);
      #1;

      // Reset behaviour: no bubble even with flush while rst is high
      step("rst_flush",   0, 1, NOP, CTL_NOP, 1, ex(4'b0000, 0, 0, 0));
      step("reset_state", 0, 0, NOP, CTL_NOP, 0, ex(4'b0000, 0, 0, 0));

      // EX forward: add $3,$1,$2 ; add $4,$3,$5
      step("add3",      0, 0, rtype(1, 2, 3, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 0));
      step("exfwd_a",   0, 0, rtype(3, 5, 4, FN_ADD), CTL_R, 0, ex(4'b1000, 0, 0, 0));
      step("nop1",      0, 0, NOP, CTL_NOP, 0, ex(4'b0000, 0, 0, 0));

      // MEM forward: add $3 ; nop ; sub $6,$7,$3
      step("add3b",     0, 0, rtype(1, 2, 3, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 0));
      step("nop2",      0, 0, NOP, CTL_NOP, 0, ex(4'b0000, 0, 0, 0));
      step("memfwd_b",  0, 0, rtype(7, 3, 6, FN_SUB), CTL_R, 0, ex(4'b0001, 0, 0, 0));

      // Both EX and MEM forwarding on both operands
      step("add3c",     0, 0, rtype(1, 2, 3, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 0));
      step("add3d",     0, 0, rtype(4, 5, 3, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 0));
      step("fwd_all",   0, 0, rtype(3, 3, 10, FN_ADD), CTL_R, 0, ex(4'b1111, 0, 0, 0));

      // Load-use with one bubble: lw $8,0($1) ; add $9,$8,$2
      step("lw8",       0, 0, itype(OP_LW, 1, 8, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 0));
      step("lu_stall",  0, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 1, 1, 0));
      step("lu_memfwd", 0, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0010, 0, 0, 1));
      step("nop3",      0, 0, NOP, CTL_NOP, 0, ex(4'b0000, 0, 0, 1));

      // $0 never forwarded or stalled on
      step("lw0",       0, 0, itype(OP_LW, 1, 0, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 1));
      step("use_r0",    0, 0, rtype(0, 0, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 1));

      // addi uses rs only
      step("lw8b",      0, 0, itype(OP_LW, 1, 8, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 1));
      step("addi_stl",  0, 0, itype(OP_ADDI, 8, 8, 1), CTL_ADDI, 0, ex(4'b0000, 1, 1, 1));
      step("addi_fwd",  0, 0, itype(OP_ADDI, 8, 8, 1), CTL_ADDI, 0, ex(4'b0010, 0, 0, 2));

      // sw stalls via rt (addi result to $8 is in MEM at the same time)
      step("lw8c",      0, 0, itype(OP_LW, 1, 8, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 2));
      step("sw_stall",  0, 0, itype(OP_SW, 2, 8, 0), CTL_SW, 0, ex(4'b0001, 1, 1, 2));
      step("sw_memfwd", 0, 0, itype(OP_SW, 2, 8, 0), CTL_SW, 0, ex(4'b0001, 0, 0, 3));

      // Flush beats hazard and suppresses forwards
      step("lw8d",      0, 0, itype(OP_LW, 1, 8, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 3));
      step("flush_hz",  0, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 1, ex(4'b0000, 0, 1, 3));
      step("flush_fwd", 0, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 1, ex(4'b0000, 0, 1, 3));
      step("nop4",      0, 0, NOP, CTL_NOP, 0, ex(4'b0000, 0, 0, 3));

      // Three bubbles per load-use
      step("b_lw8",     1, 0, itype(OP_LW, 1, 8, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 0));
      step("b_stall1",  1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 1, 1, 0));
      step("b_stall2",  1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0010, 1, 1, 1));
      step("b_stall3",  1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 1, 1, 2));
      step("b_release", 1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 3));
      step("b_nop",     1, 0, NOP, CTL_NOP, 0, ex(4'b0000, 0, 0, 3));

      // Reset in the middle of a multi-bubble stall
      step("b_lw8b",    1, 0, itype(OP_LW, 1, 8, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 3));
      step("b_stall4",  1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 1, 1, 3));
      step("b_stall5",  1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0010, 1, 1, 4));
      step("b_in_rst",  1, 1, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 5));
      step("b_post_rst",1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 0, 0, 0));

      // Flush while in the multi-bubble stall state
      step("b_lw8c",    1, 0, itype(OP_LW, 1, 8, 0), CTL_LW, 0, ex(4'b0000, 0, 0, 0));
      step("b_stall6",  1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 0, ex(4'b0000, 1, 1, 0));
      step("b_flush",   1, 0, rtype(8, 2, 9, FN_ADD), CTL_R, 1, ex(4'b0000, 0, 1, 1));
      step("b_run",     1, 0, NOP, CTL_NOP, 0, ex(4'b0000, 0, 0, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
